// File: rtl/rand_range_pkg.sv
// Shared types and constants for the bounded random-number stage.
// Holds the FSM state encoding and the saturating counter helper.
package rand_pkg;

   localparam int RAND_WIDTH    = 16;
   localparam int REJ_CNT_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      RESP = 2'd2
   } state_e;

   function automatic logic [REJ_CNT_WIDTH-1:0] sat_inc(input logic [REJ_CNT_WIDTH-1:0] v);
      return (&v) ? v : v + REJ_CNT_WIDTH'(1);
   endfunction

endpackage

// File: rtl/rand_range_if.sv
// Request/response handshake between the CPU bus logic (master) and rand_range (slave).
interface rand_range_if
   import rand_pkg::*;
#(
   parameter int WIDTH = RAND_WIDTH
);
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_limit;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_data;

   modport master (
      output req_valid,
      output req_limit,
      output rsp_ready,
      input  req_ready,
      input  rsp_valid,
      input  rsp_data
   );

   modport slave (
      input  req_valid,
      input  req_limit,
      input  rsp_ready,
      output req_ready,
      output rsp_valid,
      output rsp_data
   );

endinterface

// File: rtl/rand_range_mask_gen.sv
// Bit-smear: every bit at or below the highest set input bit becomes 1,
// giving the smallest 2^k-1 that covers the input value.
module mask_gen
   import rand_pkg::*;
#(
   parameter int WIDTH = RAND_WIDTH
) (
   input  logic [WIDTH-1:0] limit_m1_i,
   output logic [WIDTH-1:0] mask_o
);

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_smear
      assign mask_o[gi] = |limit_m1_i[WIDTH-1:gi];
   end

endmodule

// File: rtl/rand_range.sv
// Uniform random value in [0, limit) by mask-and-reject over an external LFSR,
// with a bounded number of draws and a subtract fallback on the last try.
module rand_range
   import rand_pkg::*;
#(
   parameter int WIDTH     = RAND_WIDTH,
   parameter int MAX_TRIES = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   rand_range_if.slave              bus,
   input  logic [WIDTH-1:0]         rnd_data,
   output logic                     rnd_en,
   output logic [REJ_CNT_WIDTH-1:0] reject_count
);

   localparam int          TRY_W       = $clog2(MAX_TRIES + 1);
   localparam logic [31:0] MAX_TRIES_U = 32'(MAX_TRIES);

   state_e                     state_q, state_d;
   logic [WIDTH-1:0]           limit_q, limit_d;
   logic [WIDTH-1:0]           mask_q, mask_d;
   logic [TRY_W-1:0]           tries_q, tries_d;
   logic [WIDTH-1:0]           rsp_data_q, rsp_data_d;
   logic [REJ_CNT_WIDTH-1:0]   rej_q, rej_d;

   logic [WIDTH-1:0]           limit_m1;
   logic [WIDTH-1:0]           mask_new;
   logic [WIDTH-1:0]           cand;
   logic                       last_try;
   logic                       draw_done;

   assign limit_m1 = bus.req_limit - WIDTH'(1);

   mask_gen #(.WIDTH(WIDTH)) u_mask_gen (
      .limit_m1_i (limit_m1),
      .mask_o     (mask_new)
   );

   assign cand      = rnd_data & mask_q;
   assign last_try  = (32'(tries_q) + 32'd1) >= MAX_TRIES_U;
   // limit==0 takes the raw word; limit==1 gives mask 0 so cand=0 always accepts.
   assign draw_done = (limit_q == '0) || (cand < limit_q) || last_try;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         limit_q    <= '0;
         mask_q     <= '0;
         tries_q    <= '0;
         rsp_data_q <= '0;
         rej_q      <= '0;
      end else begin
         state_q    <= state_d;
         limit_q    <= limit_d;
         mask_q     <= mask_d;
         tries_q    <= tries_d;
         rsp_data_q <= rsp_data_d;
         rej_q      <= rej_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.req_valid) state_d = DRAW;
         DRAW:    if (draw_done)     state_d = RESP;
         RESP:    if (bus.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      limit_d    = limit_q;
      mask_d     = mask_q;
      tries_d    = tries_q;
      rsp_data_d = rsp_data_q;
      rej_d      = rej_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               limit_d = bus.req_limit;
               mask_d  = mask_new;
               tries_d = '0;
            end
         end
         DRAW: begin
            if (limit_q == '0) begin
               rsp_data_d = rnd_data;
            end else if (cand < limit_q) begin
               rsp_data_d = cand;
            end else begin
               rej_d = sat_inc(rej_q);
               // mask <= 2*limit-1, so cand-limit is already in range
               if (last_try) rsp_data_d = cand - limit_q;
               else          tries_d    = tries_q + TRY_W'(1);
            end
         end
         default: ;
      endcase
   end

   // Outputs decode straight from state so reset drops them without waiting for an edge.
   always_comb begin
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      rnd_en        = 1'b0;
      case (state_q)
         IDLE:    bus.req_ready = 1'b1;
         DRAW:    rnd_en        = 1'b1;
         RESP:    bus.rsp_valid = 1'b1;
         default: ;
      endcase
   end

   assign bus.rsp_data = rsp_data_q;
   assign reject_count = rej_q;

endmodule

// File: tb/tb_rand_range.sv
// Directed bench for rand_range: scripted LFSR source, scoreboard queue checked by a monitor.
module tb_rand_range;
   import rand_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] rnd_data;
   logic        rnd_en;
   logic [15:0] reject_count;

   always #5 clk = ~clk;

   rand_range_if #(.WIDTH(16)) bus_if ();

   rand_range #(.WIDTH(16), .MAX_TRIES(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus_if),
      .rnd_data     (rnd_data),
      .rnd_en       (rnd_en),
      .reject_count (reject_count)
   );

   typedef struct {
      logic [15:0] data;
      logic [15:0] rej;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] script [64];
   int          idx = 0;
   int          pulses = 0;
   int          checks = 0;
   int          errors = 0;

   assign rnd_data = script[idx];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scripted source: advances at the edge ending each cycle rnd_en was high.
   initial begin
      forever begin
         @(negedge clk);
         if (rnd_en === 1'b1) begin
            pulses++;
            @(posedge clk);
            #1 idx++;
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus_if.rsp_valid === 1'b1 && bus_if.rsp_ready === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp: got data 0x%0h expected no response", bus_if.rsp_data);
            end else begin
               e = sb.pop_front();
               check("rsp_data", 32'(bus_if.rsp_data), 32'(e.data));
               check("reject_count", 32'(reject_count), 32'(e.rej));
               $display("rsp data=0x%04h reject_count=%0d (exp 0x%04h/%0d)",
                        bus_if.rsp_data, reject_count, e.data, e.rej);
            end
         end
      end
   end

   task automatic run_req(input string name, input logic [15:0] limit, input int n,
                          input logic [15:0] vals [4], input logic [15:0] exp_data,
                          input logic [15:0] exp_rej, input int exp_lat, input int hold);
      int          p0;
      int          cyc;
      logic [15:0] held;
      @(negedge clk);
      check({name, ":req_ready_idle"}, 32'(bus_if.req_ready), 32'd1);
      for (int k = 0; k < n; k++) script[idx + k] = vals[k];
      sb.push_back('{exp_data, exp_rej});
      p0 = pulses;
      bus_if.req_valid = 1'b1;
      bus_if.req_limit = limit;
      @(posedge clk);
      #1;
      bus_if.req_valid = 1'b0;
      bus_if.req_limit = 16'hAAAA;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (bus_if.rsp_valid !== 1'b1 && cyc < 40);
      check({name, ":latency"}, 32'(cyc), 32'(exp_lat));
      held = bus_if.rsp_data;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check({name, ":hold_data"}, 32'(bus_if.rsp_data), 32'(held));
         check({name, ":hold_valid"}, 32'(bus_if.rsp_valid), 32'd1);
         check({name, ":hold_rnd_en"}, 32'(rnd_en), 32'd0);
         check({name, ":hold_req_ready"}, 32'(bus_if.req_ready), 32'd0);
      end
      @(posedge clk);
      #1 bus_if.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus_if.rsp_ready = 1'b0;
      @(negedge clk);
      check({name, ":req_ready_after"}, 32'(bus_if.req_ready), 32'd1);
      check({name, ":rsp_valid_after"}, 32'(bus_if.rsp_valid), 32'd0);
      check({name, ":pulses"}, 32'(pulses - p0), 32'(exp_lat - 1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int k = 0; k < 64; k++) script[k] = 16'h0000;
      bus_if.req_valid = 1'b0;
      bus_if.req_limit = 16'h0000;
      bus_if.rsp_ready = 1'b0;
      #12;
      check("rst:req_ready", 32'(bus_if.req_ready), 32'd1);
      check("rst:rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
      check("rst:rnd_en", 32'(rnd_en), 32'd0);
      check("rst:reject_count", 32'(reject_count), 32'd0);
      check("rst:rsp_data", 32'(bus_if.rsp_data), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // limit 10 -> mask 0xF; 0x1234&0xF = 4 accepted on first draw
      run_req("first_accept", 16'd10, 1, '{16'h1234, 16'h0, 16'h0, 16'h0}, 16'd4, 16'd0, 2, 0);
      // 14 and 15 rejected, 3 accepted
      run_req("two_rejects", 16'd10, 3, '{16'h000E, 16'h000F, 16'h0003, 16'h0}, 16'd3, 16'd2, 4, 0);
      // limit 5 -> mask 7; four rejects then fallback 7-5=2
      run_req("fallback", 16'd5, 4, '{16'h0007, 16'h0007, 16'h0007, 16'h0007}, 16'd2, 16'd6, 5, 0);
      run_req("limit0", 16'd0, 1, '{16'hBEEF, 16'h0, 16'h0, 16'h0}, 16'hBEEF, 16'd6, 2, 0);
      run_req("limit1", 16'd1, 1, '{16'hFFFF, 16'h0, 16'h0, 16'h0}, 16'd0, 16'd6, 2, 0);
      run_req("backpressure", 16'd10, 1, '{16'h0005, 16'h0, 16'h0, 16'h0}, 16'd5, 16'd6, 2, 5);

      // Reset in the middle of a draw: nothing may come out afterwards.
      @(negedge clk);
      for (int k = 0; k < 4; k++) script[idx + k] = 16'h000E;
      bus_if.req_valid = 1'b1;
      bus_if.req_limit = 16'd10;
      @(posedge clk);
      #1 bus_if.req_valid = 1'b0;
      @(negedge clk);
      check("rstmid:in_draw", 32'(rnd_en), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rstmid:rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
      check("rstmid:rnd_en", 32'(rnd_en), 32'd0);
      check("rstmid:req_ready", 32'(bus_if.req_ready), 32'd1);
      check("rstmid:reject_count", 32'(reject_count), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bus_if.rsp_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         check("rstmid:no_rsp", 32'(bus_if.rsp_valid), 32'd0);
      end
      bus_if.rsp_ready = 1'b0;

      // limit 16 -> mask 0xF; 0xFF&0xF = 15 is the top legal value
      run_req("limit16", 16'd16, 1, '{16'h00FF, 16'h0, 16'h0, 16'h0}, 16'd15, 16'd0, 2, 0);
      // limit 6 -> mask 7; 7 rejected four times, fallback 7-6=1
      run_req("fallback6", 16'd6, 4, '{16'h0007, 16'h0007, 16'h0007, 16'h0007}, 16'd1, 16'd4, 5, 0);

      repeat (2) @(negedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
